mdc_fft_stage: RTL and testbench

- Parametrised radix-2 DIF stage for the multi-path delay-commutator (MDC) FFT pipeline. Successor to the fixed 9-bit, depth-16 stage.
- Datapath: input commutator, upper-path delay line of DELAY samples, butterfly, twiddle multiply on the lower branch.
- Adds valid gating, a self-contained phase counter, optional butterfly scaling, saturation, and an external twiddle-ROM address/data interface.
- Stages are cascaded with DELAY halving per stage.

---
 rtl/mdc_fft_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_mdc_fft_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdc_fft_stage.sv
// mdc_fft_stage: parametrised radix-2 DIF stage of an MDC FFT pipeline.
//
// Datapath: input commutator -> DELAY-deep upper-path delay line -> butterfly
// (P1, registered) -> twiddle multiply on the difference branch (P2, registered).
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   in_valid              input pair valid this cycle
//   in_up_re/im           upper input sample (WIDTH, two's complement)
//   in_lo_re/im           lower input sample (WIDTH, two's complement)
//   tw_addr               twiddle ROM address (registered)
//   tw_re/im              ROM data for tw_addr, used one cycle after the address
//   out_valid             output pair valid
//   out_up_re/im          saturated butterfly sum
//   out_lo_re/im          saturated twiddled difference
//   primed                delay line holds DELAY valid samples since reset
//
// Optional feature macro: MDC_FFT_STAGE_ROUND_EN
//   defined   -> round half-up in the twiddle multiply and in SCALE halving
//   undefined -> truncation (default)
module mdc_fft_stage #(
  parameter int unsigned WIDTH     = 9,
  parameter int unsigned DELAY     = 16,
  parameter int unsigned TW_WIDTH  = 9,
  parameter int unsigned TW_FRAC   = 7,
  parameter int unsigned TW_AW     = 4,
  parameter int unsigned TW_STRIDE = 1,
  parameter int unsigned SCALE     = 0,
  parameter int unsigned COMM_EN   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    in_up_re,
  input  logic [WIDTH-1:0]    in_up_im,
  input  logic [WIDTH-1:0]    in_lo_re,
  input  logic [WIDTH-1:0]    in_lo_im,
  output logic [TW_AW-1:0]    tw_addr,
  input  logic [TW_WIDTH-1:0] tw_re,
  input  logic [TW_WIDTH-1:0] tw_im,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_up_re,
  output logic [WIDTH-1:0]    out_up_im,
  output logic [WIDTH-1:0]    out_lo_re,
  output logic [WIDTH-1:0]    out_lo_im,
  output logic                primed
);

  localparam int unsigned CW = $clog2(2 * DELAY);
  localparam int unsigned FW = $clog2(DELAY + 1);
  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned PW = SW + TW_WIDTH;
  localparam int unsigned MW = PW + 1;

  localparam logic signed [MW-1:0] POS_MAX = {{(MW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [MW-1:0] NEG_MIN = {{(MW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`ifdef MDC_FFT_STAGE_ROUND_EN
  localparam logic signed [MW-1:0] RND   = MW'(1) << (TW_FRAC - 1);
  localparam logic signed [SW:0]   ONE_X = (SW+1)'(1);
`endif

  // Clamp a wide signed value into WIDTH bits.
  function automatic logic [WIDTH-1:0] sat(input logic signed [MW-1:0] x);
    if (x > POS_MAX)      sat = POS_MAX[WIDTH-1:0];
    else if (x < NEG_MIN) sat = NEG_MIN[WIDTH-1:0];
    else                  sat = x[WIDTH-1:0];
  endfunction

  // Halve with one guard bit so the rounding increment cannot wrap.
  function automatic logic signed [SW-1:0] half(input logic signed [SW-1:0] x);
    logic signed [SW:0] t;
    t = {x[SW-1], x};
`ifdef MDC_FFT_STAGE_ROUND_EN
    t = t + ONE_X;
`endif
    half = SW'(t >>> 1);
  endfunction

  // Sample counter, fill counter and primed flag; all advance on valid only.
  logic [CW-1:0] cnt;
  logic [FW-1:0] fill;
  logic          phase;

  // 2*DELAY is a power of two, so cnt >= DELAY is just the MSB.
  assign phase = cnt[CW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      fill   <= '0;
      primed <= 1'b0;
    end else if (in_valid) begin
      cnt <= cnt + CW'(1);
      if (!primed) begin
        fill   <= fill + FW'(1);
        primed <= (fill + FW'(1)) == FW'(DELAY);
      end
    end
  end

  // Input commutator.
  logic [WIDTH-1:0] a_re, a_im, b_re, b_im;

  always_comb begin
    a_re = in_up_re;
    a_im = in_up_im;
    b_re = in_lo_re;
    b_im = in_lo_im;
    if ((COMM_EN != 0) && phase) begin
      a_re = in_lo_re;
      a_im = in_lo_im;
      b_re = in_up_re;
      b_im = in_up_im;
    end
  end

  // Upper-path delay line; contents are never emitted before primed.
  logic [WIDTH-1:0] dl_re [DELAY];
  logic [WIDTH-1:0] dl_im [DELAY];

  always_ff @(posedge clk) begin
    if (in_valid) begin
      dl_re[0] <= a_re;
      dl_im[0] <= a_im;
      for (int i = 1; i < int'(DELAY); i++) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
    end
  end

  // Butterfly at WIDTH+1 bits with optional halving.
  logic signed [SW-1:0] ad_re_x, ad_im_x, b_re_x, b_im_x;
  logic signed [SW-1:0] sum_re_w, sum_im_w, dif_re_w, dif_im_w;
  logic signed [SW-1:0] sum_re, sum_im, dif_re, dif_im;

  always_comb begin
    ad_re_x  = {dl_re[DELAY-1][WIDTH-1], dl_re[DELAY-1]};
    ad_im_x  = {dl_im[DELAY-1][WIDTH-1], dl_im[DELAY-1]};
    b_re_x   = {b_re[WIDTH-1], b_re};
    b_im_x   = {b_im[WIDTH-1], b_im};
    sum_re_w = ad_re_x + b_re_x;
    sum_im_w = ad_im_x + b_im_x;
    dif_re_w = ad_re_x - b_re_x;
    dif_im_w = ad_im_x - b_im_x;
    sum_re   = sum_re_w;
    sum_im   = sum_im_w;
    dif_re   = dif_re_w;
    dif_im   = dif_im_w;
    if (SCALE != 0) begin
      sum_re = half(sum_re_w);
      sum_im = half(sum_im_w);
      dif_re = half(dif_re_w);
      dif_im = half(dif_im_w);
    end
  end

  // P1: butterfly results, twiddle address, valid.
  logic [WIDTH-1:0]     sum_re_q, sum_im_q;
  logic signed [SW-1:0] dif_re_q, dif_im_q;
  logic                 v1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_re_q <= '0;
      sum_im_q <= '0;
      dif_re_q <= '0;
      dif_im_q <= '0;
      tw_addr  <= '0;
      v1       <= 1'b0;
    end else begin
      sum_re_q <= sat(MW'(sum_re));
      sum_im_q <= sat(MW'(sum_im));
      dif_re_q <= dif_re;
      dif_im_q <= dif_im;
      tw_addr  <= TW_AW'((32'(cnt) & 32'(DELAY - 1)) * 32'(TW_STRIDE));
      // primed before this sample means its delayed partner is real data.
      v1       <= in_valid & primed;
    end
  end

  // Complex multiply of the difference by the twiddle, full precision.
  logic signed [TW_WIDTH-1:0] tw_re_s, tw_im_s;
  logic signed [PW-1:0]       p_rr, p_ii, p_ri, p_ir;
  logic signed [MW-1:0]       mul_re, mul_im, mul_re_r, mul_im_r, sh_re, sh_im;

  assign tw_re_s = tw_re;
  assign tw_im_s = tw_im;

  always_comb begin
    p_rr     = PW'(dif_re_q) * PW'(tw_re_s);
    p_ii     = PW'(dif_im_q) * PW'(tw_im_s);
    p_ri     = PW'(dif_re_q) * PW'(tw_im_s);
    p_ir     = PW'(dif_im_q) * PW'(tw_re_s);
    mul_re   = MW'(p_rr) - MW'(p_ii);
    mul_im   = MW'(p_ri) + MW'(p_ir);
`ifdef MDC_FFT_STAGE_ROUND_EN
    mul_re_r = mul_re + RND;
    mul_im_r = mul_im + RND;
`else
    mul_re_r = mul_re;
    mul_im_r = mul_im;
`endif
    sh_re    = mul_re_r >>> TW_FRAC;
    sh_im    = mul_im_r >>> TW_FRAC;
  end

  // P2: output register; data holds across invalid slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_up_re <= '0;
      out_up_im <= '0;
      out_lo_re <= '0;
      out_lo_im <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        out_up_re <= sum_re_q;
        out_up_im <= sum_im_q;
        out_lo_re <= sat(sh_re);
        out_lo_im <= sat(sh_im);
      end
    end
  end

endmodule

// File: tb/tb_mdc_fft_stage.sv
`timescale 1ns/1ps
module tb_mdc_fft_stage;

  localparam int W  = 9;
  localparam int D  = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst, in_valid;
  logic [W-1:0]  in_up_re, in_up_im, in_lo_re, in_lo_im;
  logic [AW-1:0] tw_addr [2];
  logic [W-1:0]  tw_re [2];
  logic [W-1:0]  tw_im [2];
  logic          o_valid [2];
  logic          o_primed [2];
  logic [W-1:0]  o_up_re [2];
  logic [W-1:0]  o_up_im [2];
  logic [W-1:0]  o_lo_re [2];
  logic [W-1:0]  o_lo_im [2];

  always #5 clk = ~clk;

  // dut0: no commutation, no scaling; dut1: commutator and halving enabled.
  mdc_fft_stage #(.WIDTH(W), .DELAY(D), .TW_WIDTH(9), .TW_FRAC(7), .TW_AW(AW),
                  .TW_STRIDE(1), .SCALE(0), .COMM_EN(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_up_re(in_up_re), .in_up_im(in_up_im), .in_lo_re(in_lo_re), .in_lo_im(in_lo_im),
    .tw_addr(tw_addr[0]), .tw_re(tw_re[0]), .tw_im(tw_im[0]),
    .out_valid(o_valid[0]), .out_up_re(o_up_re[0]), .out_up_im(o_up_im[0]),
    .out_lo_re(o_lo_re[0]), .out_lo_im(o_lo_im[0]), .primed(o_primed[0]));

  mdc_fft_stage #(.WIDTH(W), .DELAY(D), .TW_WIDTH(9), .TW_FRAC(7), .TW_AW(AW),
                  .TW_STRIDE(1), .SCALE(1), .COMM_EN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_up_re(in_up_re), .in_up_im(in_up_im), .in_lo_re(in_lo_re), .in_lo_im(in_lo_im),
    .tw_addr(tw_addr[1]), .tw_re(tw_re[1]), .tw_im(tw_im[1]),
    .out_valid(o_valid[1]), .out_up_re(o_up_re[1]), .out_up_im(o_up_im[1]),
    .out_lo_re(o_lo_re[1]), .out_lo_im(o_lo_im[1]), .primed(o_primed[1]));

  // Twiddle ROM: data presented for the current registered address.
  int rom_re [16];
  int rom_im [16];

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      tw_re[d] = 9'(rom_re[tw_addr[d]]);
      tw_im[d] = 9'(rom_im[tw_addr[d]]);
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state (shared counters, per-DUT delay lines).
  int m_cnt, m_fill, m_wp;
  int dl_re [2][D];
  int dl_im [2][D];
  int sbq [$];   // entries: due cycle, then 4 values for dut0, 4 for dut1
  int cap [$];   // observed outputs per popped entry, same layout minus due
  int taq [$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sv(input logic [W-1:0] x);
    return int'($signed(x));
  endfunction

  function automatic int sat(input longint x);
    if (x > 255)  return 255;
    if (x < -256) return -256;
    return int'(x);
  endfunction

  function automatic longint halve(input longint x);
`ifdef MDC_FFT_STAGE_ROUND_EN
    return (x + 1) >>> 1;
`else
    return x >>> 1;
`endif
  endfunction

  task automatic calc(input int ar, input int ai, input int br, input int bi,
                      input bit scale, input int twr, input int twi,
                      output int ur, output int ui, output int lr, output int li);
    longint sr, si, dr, di, pr, pi;
    sr = ar + br; si = ai + bi;
    dr = ar - br; di = ai - bi;
    if (scale) begin
      sr = halve(sr); si = halve(si);
      dr = halve(dr); di = halve(di);
    end
    pr = dr * twr - di * twi;
    pi = dr * twi + di * twr;
`ifdef MDC_FFT_STAGE_ROUND_EN
    pr = pr + 64;
    pi = pi + 64;
`endif
    ur = sat(sr);
    ui = sat(si);
    lr = sat(pr >>> 7);
    li = sat(pi >>> 7);
  endtask

  task automatic accept(input int ur, input int ui, input int lr, input int li);
    bit ph;
    int addr, ar, ai, br, bi;
    int e [8];
    ph   = (m_cnt >= D);
    addr = m_cnt % D;
    for (int d = 0; d < 2; d++) begin
      if (d == 1 && ph) begin ar = lr; ai = li; br = ur; bi = ui; end
      else              begin ar = ur; ai = ui; br = lr; bi = li; end
      calc(dl_re[d][m_wp], dl_im[d][m_wp], br, bi, d == 1, rom_re[addr], rom_im[addr],
           e[4*d], e[4*d+1], e[4*d+2], e[4*d+3]);
      dl_re[d][m_wp] = ar;
      dl_im[d][m_wp] = ai;
    end
    if (m_fill == D) begin
      sbq.push_back(cyc + 1);
      for (int i = 0; i < 8; i++) sbq.push_back(e[i]);
    end
    m_wp  = (m_wp + 1) % D;
    if (m_fill < D) m_fill++;
    m_cnt = (m_cnt + 1) % (2 * D);
  endtask

  // One clock: drive, let the DUT sample, update the model, compare.
  task automatic step(input bit r, input bit v, input int ur, input int ui,
                      input int lr, input int li);
    int pre_cnt;
    bit ev;
    rst = r; in_valid = v;
    in_up_re = 9'(ur); in_up_im = 9'(ui);
    in_lo_re = 9'(lr); in_lo_im = 9'(li);
    @(posedge clk);
    cyc++;
    pre_cnt = m_cnt;
    if (r) begin
      m_cnt = 0; m_fill = 0; m_wp = 0;
      sbq.delete();
    end else if (v) begin
      accept(ur, ui, lr, li);
    end
    #1;
    ev = (sbq.size() > 0) && (sbq[0] == cyc);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("primed%0d", d), int'(o_primed[d]), (m_fill == D) ? 1 : 0);
      check($sformatf("tw_addr%0d", d), int'(tw_addr[d]), r ? 0 : pre_cnt % D);
      check($sformatf("out_valid%0d", d), int'(o_valid[d]), int'(ev));
      if (r) begin
        check($sformatf("rst_up_re%0d", d), sv(o_up_re[d]), 0);
        check($sformatf("rst_up_im%0d", d), sv(o_up_im[d]), 0);
        check($sformatf("rst_lo_re%0d", d), sv(o_lo_re[d]), 0);
        check($sformatf("rst_lo_im%0d", d), sv(o_lo_im[d]), 0);
      end
    end
    if (ev) begin
      for (int d = 0; d < 2; d++) begin
        if (o_valid[d]) begin
          check($sformatf("up_re%0d", d), sv(o_up_re[d]), sbq[1+4*d]);
          check($sformatf("up_im%0d", d), sv(o_up_im[d]), sbq[2+4*d]);
          check($sformatf("lo_re%0d", d), sv(o_lo_re[d]), sbq[3+4*d]);
          check($sformatf("lo_im%0d", d), sv(o_lo_im[d]), sbq[4+4*d]);
        end
        cap.push_back(sv(o_up_re[d]));
        cap.push_back(sv(o_up_im[d]));
        cap.push_back(sv(o_lo_re[d]));
        cap.push_back(sv(o_lo_im[d]));
      end
      for (int i = 0; i < 9; i++) void'(sbq.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic rom_fill(input int re, input int im);
    for (int i = 0; i < 16; i++) begin rom_re[i] = re; rom_im[i] = im; end
  endtask

  function automatic int rv();
    if ($urandom_range(3, 0) == 0) return ($urandom_range(1, 0) == 1) ? 255 : -256;
    return int'($urandom_range(511, 0)) - 256;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    in_up_re = '0; in_up_im = '0; in_lo_re = '0; in_lo_im = '0;
    m_cnt = 0; m_fill = 0; m_wp = 0;
    rom_fill(128, 0);

    // Reset held with valid traffic present.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 77, -5, -100, 33);

    // Ramp: up = 10k, lo = k, unity twiddle.
    cap.delete();
    for (int k = 1; k <= 10; k++) step(1'b0, 1'b1, 10 * k, 0, k, 0);
    idle(3);
    check("ramp_count", cap.size(), 6 * 8);
    check("ramp0_up_re", cap[0], 15);
    check("ramp0_up_im", cap[1], 0);
    check("ramp0_lo_re", cap[2], 5);
    check("ramp0_lo_im", cap[3], 0);
    check("ramp1_up_re", cap[8], 26);
    check("ramp1_lo_re", cap[10], 14);

    // Saturating corner: A_d = (255,255), B = (255,-256).
    step(1'b1, 1'b0, 0, 0, 0, 0);
    cap.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 255, 255, 0, 0);
    step(1'b0, 1'b1, 255, -256, 255, -256);
    idle(3);
    check("sat_count", cap.size(), 8);
    check("sat0_up_re", cap[0], 255);
    check("sat0_up_im", cap[1], -1);
    check("sat0_lo_im", cap[3], 255);
    check("sat1_up_re", cap[4], 255);
`ifdef MDC_FFT_STAGE_ROUND_EN
    check("sat1_up_im", cap[5], 0);
`else
    check("sat1_up_im", cap[5], -1);
`endif
    check("sat1_lo_re", cap[6], 0);
    check("sat1_lo_im", cap[7], 255);

    // -j twiddle and address sequence.
    rom_fill(0, -128);
    step(1'b1, 1'b0, 0, 0, 0, 0);
    cap.delete();
    taq.delete();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) step(1'b0, 1'b1, 10, 3, 7, -7);
      else        step(1'b0, 1'b1, 0, 0, 0, 0);
      taq.push_back(int'(tw_addr[0]));
    end
    idle(3);
    for (int i = 0; i < 8; i++) check($sformatf("addr_seq%0d", i), taq[i], i % 4);
    check("negj_up_re", cap[0], 10);
    check("negj_lo_re", cap[2], 3);
    check("negj_lo_im", cap[3], -10);

    // In-valid gaps of two cycles with a varied twiddle table.
    for (int i = 0; i < 16; i++) begin
      rom_re[i] = int'($urandom_range(511, 0)) - 256;
      rom_im[i] = int'($urandom_range(511, 0)) - 256;
    end
    step(1'b1, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, rv(), rv(), rv(), rv());
      idle(2);
    end

    // Random traffic with random gaps.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) != 0) step(1'b0, 1'b1, rv(), rv(), rv(), rv());
      else                           step(1'b0, 1'b0, rv(), rv(), rv(), rv());
    end
    idle(3);

    // Mid-frame reset after 6 inputs, then restart.
    rom_fill(100, -50);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, rv(), rv(), rv(), rv());
    step(1'b1, 1'b1, rv(), rv(), rv(), rv());
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, rv(), rv(), rv(), rv());
    idle(3);

    // Half-LSB product: truncates to 0, rounds to 1.
    rom_fill(64, 0);
    step(1'b1, 1'b0, 0, 0, 0, 0);
    cap.delete();
    step(1'b0, 1'b1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0, 0, 0, 0);
    idle(3);
`ifdef MDC_FFT_STAGE_ROUND_EN
    check("half_lsb_lo_re", cap[2], 1);
`else
    check("half_lsb_lo_re", cap[2], 0);
`endif
    check("drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
